// File: rtl/dmem_lsu.sv
// Load/store unit between the pipeline and a one-cycle-latency data memory port.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into access faults.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | ready for a new request
//  ISSUE   | address/size/data driven to memory; write strobe for stores
//  WAIT    | load data returning from memory, captured at exit
//  RESP    | response held until the pipeline takes it
module dmem_lsu #(
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [2:0]                 i_req_funct3,
    input  logic [31:0]                i_req_addr,
    input  logic [31:0]                i_req_wdata,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [31:0]                o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic [DMEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                       o_mem_we,
    output logic [1:0]                 o_mem_size,
    output logic [31:0]                o_mem_din,
    input  logic [31:0]                i_mem_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]                 state;
    logic [1:0]                 state_nxt;
    logic                       req_we_q;
    logic [2:0]                 funct3_q;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                wdata_q;
    logic [31:0]                rdata_q;
    logic                       err_q;

    logic accept;
    logic addr_oob;
    logic funct3_bad;
    logic store_bad;
    logic misalign;
    logic illegal;

    // The upper-address check vanishes when the memory spans the full 32-bit space.
    if (DMEM_ADDR_WIDTH < 32) begin : g_oob
        assign addr_oob = |i_req_addr[31:DMEM_ADDR_WIDTH];
    end else begin : g_no_oob
        assign addr_oob = 1'b0;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0])
                   || ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign funct3_bad = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110)
                     || (i_req_funct3 == 3'b111);
    assign store_bad  = i_req_we && i_req_funct3[2];
    assign illegal    = funct3_bad || store_bad || addr_oob || misalign;

    // Gated by reset so the port reads not-ready while reset is held.
    assign o_req_ready = (state == S_IDLE) && i_rst_n;
    assign accept      = i_req_valid && o_req_ready;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b100:  r = {24'd0, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b101:  r = {16'd0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = illegal ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = req_we_q ? S_RESP : S_WAIT;
            S_WAIT:  state_nxt = S_RESP;
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            req_we_q <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_we_q <= i_req_we;
                funct3_q <= i_req_funct3;
                addr_q   <= i_req_addr[DMEM_ADDR_WIDTH-1:0];
                wdata_q  <= i_req_wdata;
                rdata_q  <= 32'd0;
                err_q    <= illegal;
            end
            if (state == S_WAIT) begin
                rdata_q <= load_ext(funct3_q, i_mem_dout);
            end
        end
    end

    // Write strobe decodes straight from state so an async reset drops it at once.
    assign o_mem_we    = (state == S_ISSUE) && req_we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_size  = funct3_q[1:0];
    assign o_mem_din   = wdata_q;
    assign o_rsp_valid = (state == S_RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a byte-addressed one-cycle-latency memory model.
module tb_dmem_lsu;

    localparam int AW = 12;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic          i_req_we = 1'b0;
    logic [2:0]    i_req_funct3 = 3'd0;
    logic [31:0]   i_req_addr = 32'd0;
    logic [31:0]   i_req_wdata = 32'd0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_err;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_we;
    logic [1:0]    o_mem_size;
    logic [31:0]   o_mem_din;
    logic [31:0]   i_mem_dout = 32'd0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
    } exp_t;
    exp_t sb[$];

    logic [7:0]    mem [0:(1<<AW)-1];
    int            we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    logic [1:0]    we_size = 2'd0;

    dmem_lsu #(.DMEM_ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
        .o_mem_size(o_mem_size), .o_mem_din(o_mem_din),
        .i_mem_dout(i_mem_dout)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = i[7:0];
    end

    // Memory model: read data appears one cycle after the address is sampled.
    always @(posedge i_clk) begin
        logic [AW-1:0] a0, a1, a2, a3;
        a0 = o_mem_addr;
        a1 = a0 + 1'b1;
        a2 = a0 + 2'd2;
        a3 = a0 + 2'd3;
        i_mem_dout <= {mem[a3], mem[a2], mem[a1], mem[a0]};
        if (o_mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = o_mem_addr;
            we_size = o_mem_size;
            mem[a0] = o_mem_din[7:0];
            if (o_mem_size != 2'b00) mem[a1] = o_mem_din[15:8];
            if (o_mem_size == 2'b10) begin
                mem[a2] = o_mem_din[23:16];
                mem[a3] = o_mem_din[31:24];
            end
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_we,
                          input int hold, input string name);
        exp_t e;
        exp_t got;
        int   n;
        int   lat;
        int   we0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.we    = exp_we;
        sb.push_back(e);
        n = 0;
        while (!o_req_ready && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b want 1", name, o_req_ready);
        end
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        i_rsp_ready  = (hold == 0);
        we0 = we_cnt;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        lat = 1;
        while (!o_rsp_valid && lat < 8) begin
            @(posedge i_clk); #1;
            lat++;
        end
        got = sb.pop_front();
        checks++;
        if (o_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rsp_timeout: got valid=%b want 1", name, o_rsp_valid);
        end
        checks++;
        if (o_rsp_rdata !== got.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, o_rsp_rdata, got.rdata);
        end
        checks++;
        if (o_rsp_err !== got.err) begin
            errors++;
            $display("FAIL %s err: got %b want %b", name, o_rsp_err, got.err);
        end
        checks++;
        if (lat != got.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, got.lat);
        end
        checks++;
        if (we_cnt - we0 != got.we) begin
            errors++;
            $display("FAIL %s we_cycles: got %0d want %0d", name, we_cnt - we0, got.we);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== got.rdata || o_rsp_err !== got.err
                || o_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b d=%h e=%b r=%b want v=1 d=%h e=%b r=0",
                         name, k, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready,
                         got.rdata, got.err);
            end
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s retire: got valid=%b ready=%b want 0/1", name, o_rsp_valid, o_req_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_we, o_mem_addr,
             o_mem_size, o_mem_din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h e=%b we=%b a=%h s=%b din=%h want all 0",
                     o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_we, o_mem_addr,
                     o_mem_size, o_mem_din);
        end
        @(posedge i_clk); #3;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", o_req_ready);
        end
    endtask

    task automatic test_misalign();
        do_req(1'b0, 3'b001, 32'h11, 32'h0, TRAP ? 32'h0 : 32'h0000_1211, TRAP, TRAP ? 1 : 3, 0, 0, "lh_0x11");
        do_req(1'b0, 3'b010, 32'h11, 32'h0, TRAP ? 32'h0 : 32'h1413_1211, TRAP, TRAP ? 1 : 3, 0, 0, "lw_0x11");
        do_req(1'b1, 3'b001, 32'h31, 32'h0000_AAAA, 32'h0, TRAP, TRAP ? 1 : 2, TRAP ? 0 : 1, 0, "sh_0x31");
    endtask

    task automatic test_store_load();
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 0, "sw_0x10");
        checks++;
        if (we_addr !== 12'h010 || we_size !== 2'b10) begin
            errors++;
            $display("FAIL sw_port: got addr=%h size=%b want 010/10", we_addr, we_size);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0, 0, "lw_0x10");
    endtask

    task automatic test_sign_ext();
        do_req(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, 32'h0, 1'b0, 2, 1, 0, "sw_pattern");
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 0, 0, "lb_0x13");
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 3, 0, 0, "lbu_0x13");
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_0001, 1'b0, 3, 0, 0, "lb_0x10");
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_80FF, 1'b0, 3, 0, 0, "lh_0x12");
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_80FF, 1'b0, 3, 0, 0, "lhu_0x12");
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 32'h0000_7F01, 1'b0, 3, 0, 0, "lh_0x10");
    endtask

    task automatic test_illegal();
        do_req(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1, 0, 0, "lw_oob");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, "f3_011");
        do_req(1'b1, 3'b100, 32'h40, 32'h55, 32'h0, 1'b1, 1, 0, 0, "store_f3_100");
        do_req(1'b1, 3'b010, 32'h8000_0040, 32'h55, 32'h0, 1'b1, 1, 0, 0, "sw_oob");
        do_req(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, "f3_110");
        do_req(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, "f3_111");
        checks++;
        if (mem_word(32'h40) !== 32'h4342_4140) begin
            errors++;
            $display("FAIL illegal_no_write: got %h want 43424140", mem_word(32'h40));
        end
    endtask

    task automatic test_back_pressure();
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h80FF_7F01, 1'b0, 3, 0, 5, "lw_hold");
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 3, "err_hold");
    endtask

    task automatic test_reset_in_issue();
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h20;
        i_req_wdata  = 32'h1234_5678;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        checks++;
        if (o_mem_we !== 1'b1) begin
            errors++;
            $display("FAIL issue_we: got %b want 1", o_mem_we);
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_mem_we !== 1'b0 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0
            || o_mem_addr !== '0 || o_mem_din !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_issue: got we=%b v=%b rdy=%b a=%h din=%h want 0",
                     o_mem_we, o_rsp_valid, o_req_ready, o_mem_addr, o_mem_din);
        end
        @(posedge i_clk); #3;
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b want 1", o_req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL discarded_rsp%0d: got valid=%b want 0", k, o_rsp_valid);
            end
        end
        checks++;
        if (mem_word(32'h20) !== 32'h2322_2120) begin
            errors++;
            $display("FAIL mem_unchanged: got %h want 23222120", mem_word(32'h20));
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h2322_2120, 1'b0, 3, 0, 0, "lw_after_reset");
    endtask

    initial begin
        test_reset();
        test_misalign();
        test_store_load();
        test_sign_ext();
        test_illegal();
        test_back_pressure();
        test_reset_in_issue();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DMEM_ADDR_WIDTH, default 12, byte-address width of the data memory port.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_req_valid  input  1  pipeline request valid.
REQ-005 SHALL have port o_req_ready  output  1  LSU can accept a request.
REQ-006 SHALL have port i_req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port i_req_funct3  input  3  RV32I load/store funct3.
REQ-008 SHALL have port i_req_addr  input  32  byte address.
REQ-009 SHALL have port i_req_wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port o_rsp_valid  output  1  response valid.
REQ-011 SHALL have port i_rsp_ready  input  1  pipeline accepts the response.
REQ-012 SHALL have port o_rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port o_rsp_err  output  1  access fault.
REQ-014 SHALL have port o_mem_addr  output  DMEM_ADDR_WIDTH  address to the data memory write/read port.
REQ-015 SHALL have port o_mem_we  output  1  memory write enable.
REQ-016 SHALL have port o_mem_size  output  2  00 byte, 01 half, 10 word.
REQ-017 SHALL have port o_mem_din  output  32  memory write data.
REQ-018 SHALL have port i_mem_dout  input  32  memory read data, valid one cycle after the address is sampled.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-020 On handshake (i_req_valid & o_req_ready), SHALL register we, funct3, addr and wdata, and go to ISSUE, or to RESP with err=1 if the request is illegal.
REQ-021 Illegal request: funct3 in {011,110,111}, or a store with funct3[2]=1, or addr[31:DMEM_ADDR_WIDTH] != 0; no memory access SHALL occur.
REQ-022 o_mem_addr SHALL equal the registered addr[DMEM_ADDR_WIDTH-1:0], o_mem_size SHALL equal the registered funct3[1:0], and o_mem_din SHALL equal the registered wdata in all states.
REQ-023 o_mem_we SHALL be 1 for exactly the one ISSUE cycle of a store and 0 otherwise.
REQ-024 Transitions: a store SHALL go ISSUE->RESP; a load SHALL go ISSUE->WAIT->RESP; in RESP with i_rsp_ready=1 the FSM SHALL go to IDLE; otherwise RESP SHALL hold.
REQ-025 At the WAIT->RESP edge, SHALL capture i_mem_dout and extend it: LB sign-extends [7:0], LBU zero-extends [7:0], LH sign-extends [15:0], LHU zero-extends [15:0], and LW passes 32 bits.
REQ-026 Latency from the handshake edge to o_rsp_valid=1: 3 cycles for a load, 2 for a store, 1 for an illegal request.
REQ-027 o_rsp_valid SHALL be 1 only in RESP; o_rsp_rdata and o_rsp_err SHALL stay stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-028 No request SHALL be accepted in the cycle a response retires; the next accept SHALL be possible one cycle after the RESP->IDLE transition.

Reset
REQ-029 Asserting i_rst_n=0 SHALL immediately force the state to IDLE and all registered fields to 0.
REQ-030 During reset, o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_we=0, o_mem_addr=0, o_mem_size=0 and o_mem_din=0.
REQ-031 Reset asserted in ISSUE SHALL deassert o_mem_we combinationally; an in-flight response SHALL be discarded.
REQ-032 o_req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN, when defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL be illegal per REQ-021 and SHALL return err=1 with no memory access.
REQ-034 When LSU_MISALIGN_TRAP_EN is undefined: misaligned accesses SHALL be issued unchanged, since the memory handles unaligned bytes, and err=0.

Verification
REQ-035 SW addr=0x10, data=0xDEADBEEF, then LW 0x10 -> o_mem_we high for 1 cycle at addr 0x10, size 10; load rdata=0xDEADBEEF after 3 cycles, err=0.
REQ-036 LB and LBU at 0x13 over word 0x80FF7F01 -> LB rdata=0xFFFFFF80 and LBU rdata=0x00000080, each with o_rsp_valid 3 cycles after the accept.
REQ-037 LW addr=0x00001000 (DMEM_ADDR_WIDTH=12) and funct3=011 -> err=1, rdata=0, o_mem_we never asserted, o_rsp_valid 1 cycle after the accept.
REQ-038 LH addr=0x11: with LSU_MISALIGN_TRAP_EN -> err=1 and no access; without it -> rdata equals sign-extended bytes {0x12,0x11}, err=0.
REQ-039 Hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid, rdata and err stable and o_req_ready=0; release -> IDLE the next cycle.
REQ-040 Assert i_rst_n=0 during ISSUE of an SW -> o_mem_we falls immediately, memory word unchanged, no response; o_req_ready=1 after release.
